// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - store path types, size masks and size/alignment helpers
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ1,
        WAIT1,
        REQ2,
        WAIT2,
        DONE
    } st_state_e;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } st_size_e;

    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

    // SB wins over SH; neither selected means a full word.
    function automatic st_size_e decode_size(input logic sb, input logic sh);
        if (sb) begin
            return SZ_B;
        end else if (sh) begin
            return SZ_H;
        end
        return SZ_W;
    endfunction

    // Byte stores can never be misaligned.
    function automatic logic is_misaligned(input st_size_e size, input logic [1:0] off);
        return ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// rtl/store_lane_align.sv - byte-lane alignment of store data and enables over two words
module store_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off_i,
    input  st_size_e    size_i,
    input  logic [31:0] data_i,
    output logic [7:0]  be8_o,
    output logic [63:0] d64_o
);

    logic [3:0] mask;

    // Shift the size mask and data up by the byte offset into a two-word window.
    always_comb begin
        mask = BE_W;
        case (size_i)
            SZ_B:    mask = BE_B;
            SZ_H:    mask = BE_H;
            default: mask = BE_W;
        endcase
        be8_o = {4'b0000, mask} << off_i;
        d64_o = {32'h0, data_i} << {off_i, 3'b000};
    end

endmodule

// File: rtl/store_unit.sv
// rtl/store_unit.sv - store request to data-memory req/gnt/ack bus; STORE_MISALIGN_SPLIT_EN enables two-beat misaligned stores
module store_unit
    import lsu_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             st_valid_i,
    output logic             st_ready_o,
    input  logic [Width-1:0] st_addr_i,
    input  logic [Width-1:0] st_data_i,
    input  logic             SB,
    input  logic             SH,
    output logic             st_done_o,
    output logic             st_err_o,
    output logic             mem_req_o,
    input  logic             mem_gnt_i,
    output logic             mem_we_o,
    output logic [Width-1:0] mem_addr_o,
    output logic [Width-1:0] mem_wdata_o,
    output logic [3:0]       mem_be_o,
    input  logic             mem_rvalid_i
);

    st_state_e        state_q;
    logic             mem_req_q;
    logic [Width-1:0] mem_addr_q;
    logic [Width-1:0] mem_wdata_q;
    logic [3:0]       mem_be_q;
    logic             done_q;
    logic             err_q;

    st_size_e         size;
    logic [7:0]       be8;
    logic [63:0]      d64;
    logic             reject;

    assign size = decode_size(SB, SH);

    // Aligned on the request as it is accepted, so beat 1 is on the bus the cycle after accept.
    store_lane_align u_align (
        .off_i  (st_addr_i[1:0]),
        .size_i (size),
        .data_i (st_data_i),
        .be8_o  (be8),
        .d64_o  (d64)
    );

`ifdef STORE_MISALIGN_SPLIT_EN
    logic             need_hi_q;
    logic [3:0]       hi_be_q;
    logic [Width-1:0] hi_wdata_q;

    assign reject = 1'b0;
`else
    logic unused_hi;

    assign unused_hi = ^{be8[7:4], d64[63:32]};
    assign reject    = is_misaligned(size, st_addr_i[1:0]);
`endif

    // Store FSM with registered bus and completion outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= 4'b0000;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
            need_hi_q   <= 1'b0;
            hi_be_q     <= 4'b0000;
            hi_wdata_q  <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (st_valid_i) begin
                        state_q <= REQ1;
                        err_q   <= reject;
                        // A rejected store leaves the bus outputs untouched.
                        if (!reject) begin
                            mem_req_q   <= 1'b1;
                            mem_addr_q  <= {st_addr_i[Width-1:2], 2'b00};
                            mem_be_q    <= be8[3:0];
                            mem_wdata_q <= d64[31:0];
                        end
`ifdef STORE_MISALIGN_SPLIT_EN
                        need_hi_q  <= |be8[7:4];
                        hi_be_q    <= be8[7:4];
                        hi_wdata_q <= d64[63:32];
`endif
                    end
                end
                REQ1: begin
                    if (!mem_req_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else if (mem_gnt_i) begin
                        state_q   <= WAIT1;
                        mem_req_q <= 1'b0;
                    end
                end
                WAIT1: begin
                    if (mem_rvalid_i) begin
`ifdef STORE_MISALIGN_SPLIT_EN
                        if (need_hi_q) begin
                            state_q     <= REQ2;
                            mem_req_q   <= 1'b1;
                            mem_addr_q  <= mem_addr_q + Width'(4);
                            mem_be_q    <= hi_be_q;
                            mem_wdata_q <= hi_wdata_q;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
`else
                        state_q <= DONE;
                        done_q  <= 1'b1;
`endif
                    end
                end
`ifdef STORE_MISALIGN_SPLIT_EN
                REQ2: begin
                    if (mem_gnt_i) begin
                        state_q   <= WAIT2;
                        mem_req_q <= 1'b0;
                    end
                end
                WAIT2: begin
                    if (mem_rvalid_i) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
`endif
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                    done_q    <= 1'b0;
                    err_q     <= 1'b0;
                end
            endcase
        end
    end

    assign st_ready_o  = (state_q == IDLE);
    assign st_done_o   = done_q;
    assign st_err_o    = err_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_req_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_be_o    = mem_be_q;

endmodule

// File: tb/tb_store_unit.sv
// tb/tb_store_unit.sv - self-checking bench for store_unit against a byte-level store model
module tb_store_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        st_valid_i = 1'b0;
    logic        st_ready_o;
    logic [31:0] st_addr_i = '0;
    logic [31:0] st_data_i = '0;
    logic        SB = 1'b0;
    logic        SH = 1'b0;
    logic        st_done_o;
    logic        st_err_o;
    logic        mem_req_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_rvalid_i = 1'b0;

    int errors = 0;
    int checks = 0;

    store_unit #(.Width(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .st_valid_i   (st_valid_i),
        .st_ready_o   (st_ready_o),
        .st_addr_i    (st_addr_i),
        .st_data_i    (st_data_i),
        .SB           (SB),
        .SH           (SH),
        .st_done_o    (st_done_o),
        .st_err_o     (st_err_o),
        .mem_req_o    (mem_req_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_be_o     (mem_be_o),
        .mem_rvalid_i (mem_rvalid_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // sz: 0 byte, 1 half, 2 word. gdly: cycles grant is withheld; rdly: cycles from grant to ack.
    task automatic run_store(input logic [31:0] addr, input logic [31:0] data, input int sz,
                             input int gdly, input int rdly, input logic rv_with_gnt);
        logic [31:0] ea[2];
        logic [3:0]  eb[2];
        logic [31:0] ed[2];
        int          nb;
        logic        eerr;
        int          cyc;
        int          beat;
        int          idx;
        logic        done_seen;
        logic [31:0] h_addr;
        logic [31:0] h_wd;
        logic [3:0]  h_be;

        // Model: walk the stored bytes, group them by the word each lands in.
        nb = 0;
        eerr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ea[k] = '0;
            eb[k] = '0;
            ed[k] = '0;
        end
`ifndef STORE_MISALIGN_SPLIT_EN
        if ((sz == 1 && addr[0]) || (sz == 2 && addr[1:0] != 2'b00)) eerr = 1'b1;
`endif
        if (!eerr) begin
            for (int i = 0; i < (1 << sz); i++) begin
                logic [31:0] a;
                logic [31:0] w;
                a = addr + 32'(i);
                w = {a[31:2], 2'b00};
                if (nb == 0 || w != ea[nb-1]) begin
                    ea[nb] = w;
                    nb++;
                end
                eb[nb-1][a[1:0]] = 1'b1;
                ed[nb-1][8*a[1:0] +: 8] = data[8*i +: 8];
            end
        end

        chk("ready_before_accept", {31'b0, st_ready_o}, 32'd1);
        st_valid_i = 1'b1;
        st_addr_i  = addr;
        st_data_i  = data;
        SB = (sz == 0);
        SH = (sz == 1);
        step();
        cyc = 1;
        beat = 0;
        done_seen = 1'b0;

        while (!done_seen && cyc < 100) begin
            if (st_done_o) begin
                done_seen = 1'b1;
            end else if (mem_req_o) begin
                idx = (beat < 2) ? beat : 1;
                chk("beat_in_range", {31'b0, beat < nb}, 32'd1);
                chk("we_eq_req", {31'b0, mem_we_o}, 32'd1);
                chk("beat_addr", mem_addr_o, ea[idx]);
                chk("beat_be", {28'b0, mem_be_o}, {28'b0, eb[idx]});
                chk("beat_wdata", mem_wdata_o & lane_mask(mem_be_o), ed[idx]);
                h_addr = mem_addr_o;
                h_wd   = mem_wdata_o;
                h_be   = mem_be_o;
                for (int g = 0; g < gdly; g++) begin
                    step();
                    cyc++;
                    chk("req_held", {31'b0, mem_req_o}, 32'd1);
                    chk("addr_stable", mem_addr_o, h_addr);
                    chk("wdata_stable", mem_wdata_o, h_wd);
                    chk("be_stable", {28'b0, mem_be_o}, {28'b0, h_be});
                end
                mem_gnt_i = 1'b1;
                mem_rvalid_i = rv_with_gnt;
                step();
                cyc++;
                mem_gnt_i = 1'b0;
                mem_rvalid_i = 1'b0;
                chk("req_drop_after_gnt", {31'b0, mem_req_o}, 32'd0);
                for (int r = 1; r < rdly; r++) begin
                    step();
                    cyc++;
                    chk("no_done_while_wait", {31'b0, st_done_o}, 32'd0);
                end
                mem_rvalid_i = 1'b1;
                step();
                cyc++;
                mem_rvalid_i = 1'b0;
                beat++;
            end else begin
                step();
                cyc++;
            end
        end

        st_valid_i = 1'b0;
        chk("done_seen", {31'b0, done_seen}, 32'd1);
        chk("beat_count", 32'(beat), 32'(nb));
        chk("err", {31'b0, st_err_o}, {31'b0, eerr});
        chk("latency", 32'(cyc), (nb == 0) ? 32'd2 : 32'(1 + nb * (gdly + 1 + rdly)));
        step();
        chk("done_single_pulse", {31'b0, st_done_o}, 32'd0);
        chk("ready_after_done", {31'b0, st_ready_o}, 32'd1);
    endtask

    initial begin
        step();
        step();
        chk("rst_req", {31'b0, mem_req_o}, 32'd0);
        chk("rst_we", {31'b0, mem_we_o}, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_wdata", mem_wdata_o, 32'd0);
        chk("rst_be", {28'b0, mem_be_o}, 32'd0);
        chk("rst_done", {31'b0, st_done_o}, 32'd0);
        chk("rst_err", {31'b0, st_err_o}, 32'd0);
        chk("rst_ready", {31'b0, st_ready_o}, 32'd1);
        rst_i = 1'b0;
        step();

        run_store(32'h0000_0100, 32'hDEAD_BEEF, 2, 0, 1, 1'b0);
        run_store(32'h0000_0103, 32'h0000_00A5, 0, 0, 1, 1'b0);
        run_store(32'h0000_01FF, 32'h0000_1234, 1, 0, 1, 1'b0);
        run_store(32'h0000_0201, 32'h0000_5678, 1, 1, 1, 1'b0);
        run_store(32'h0000_0300, 32'hCAFE_F00D, 2, 3, 2, 1'b0);
        run_store(32'h0000_0404, 32'h1357_9BDF, 2, 0, 2, 1'b1);
        run_store(32'hFFFF_FFFE, 32'hAABB_CCDD, 2, 0, 1, 1'b0);
        run_store(32'h0000_0502, 32'h0000_BEEF, 1, 2, 3, 1'b0);

        // Reset while waiting for the write acknowledge.
        st_valid_i = 1'b1;
        st_addr_i = 32'h0000_0040;
        st_data_i = 32'h1111_2222;
        SB = 1'b0;
        SH = 1'b0;
        step();
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        st_valid_i = 1'b0;
        chk("rst_wait1_req", {31'b0, mem_req_o}, 32'd0);
        chk("rst_wait1_ready", {31'b0, st_ready_o}, 32'd1);
        mem_rvalid_i = 1'b1;
        step();
        mem_rvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("late_rvalid_no_done", {31'b0, st_done_o}, 32'd0);
            step();
        end

        // Reset while requesting with grant withheld.
        st_valid_i = 1'b1;
        step();
        chk("req1_req", {31'b0, mem_req_o}, 32'd1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        st_valid_i = 1'b0;
        chk("rst_req1_req", {31'b0, mem_req_o}, 32'd0);
        chk("rst_req1_ready", {31'b0, st_ready_o}, 32'd1);
        step();

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3))) : $urandom;
            run_store(a, $urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                      int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
